fetch_bpu: RTL
==============

// Module: fetch_bpu
// PURPOSE
//  Next-generation fetch-stage pre-decoder and branch predictor. It pre-decodes the
//  fetched instruction and produces a predicted-taken flag and target for JAL, JALR,
//  Bxx and MRET. Bxx direction comes from a parametrised BHT of 2-bit saturating
//  counters (or from static backward-taken). Returns use a parametrised return
//  address stack (RAS). It sits between the fetch PC mux and the IR register, and the
//  execute stage trains it.
// PARAMETERS
//  BHT_ENTRIES  64  number of 2-bit counters; power of 2, >=2; index = fet_pc[IDXW+1:2]
//  RAS_DEPTH    4   return address stack entries; power of 2, >=2
//  USE_BHT      1   1: BHT direction; 0: static, taken iff instr[31] (backward)
// PORTS
//  clk           in   1   clock
//  rst           in   1   reset, asynchronous, active-high
//  fet_valid     in   1   fet_instr/fet_pc valid this cycle
//  fet_pc        in   32  PC of fetched instruction
//  fet_instr     in   32  fetched RV32 instruction
//  r_x1          in   32  current x1 value (fast path)
//  rs3v          in   32  regfile read of instr[19:15] (xn path)
//  rs1_busy      in   1   an in-flight older instruction writes instr[19:15]
//  mepc          in   32  MRET target
//  upd_valid     in   1   execute-stage resolved Bxx
//  upd_pc        in   32  PC of the resolved Bxx
//  upd_taken     in   1   actual direction
//  flush         in   1   pipeline redirect (mispredict/trap)
//  pred_valid    out  1   prediction present this cycle
//  pred_taken    out  1   redirect fetch to pred_target
//  pred_target   out  32  predicted next PC
//  fetch_stall   out  1   hold fetch PC/IR this cycle
//  ras_empty     out  1   RAS holds no valid entry
// BEHAVIOUR
//  - Decode: JAL=1101111, JALR=1100111, BRANCH=1100011, MRET=SYSTEM with instr[31:25]=7'h18.
//    Link reg = x1 or x5. Immediates are sign-extended per RV32I. All targets are mod 2^32.
//  - Outputs are combinational from the current state and inputs (0-cycle latency).
//    With fet_valid=0 or rst=1, every output is 0 except ras_empty=1.
//  - JAL: taken, target=fet_pc+jimm.
//  - Bxx: target=fet_pc+bimm. When USE_BHT=1, taken = counter[idx][1].
//  - MRET: taken, target=mepc.
//  - JALR pop case (rs1 is a link reg, rd is not): RAS non-empty -> target=top, no stall.
//    RAS empty -> fall through to the JALR xn path.
//  - JALR xn path: base = r_x1 if rs1==x1, rs3v if rs1 not in {x0,x1}, 0 if rs1==x0.
//    If rs1 is not x0 and rs1_busy=1 -> fetch_stall=1, pred_valid=0.
//    Otherwise target = (base + iimm) & ~1, taken.
//  - RAS (circular; top pointer tp, count cnt). State changes only when
//    fet_valid & ~fetch_stall & ~flush.
//    Push: JAL/JALR with rd=link. Store fet_pc+4 at tp+1; tp++; cnt=min(cnt+1,DEPTH).
//    On full, the oldest entry is overwritten.
//    Pop: see pop case. tp--, cnt-- if cnt>0. Empty pop leaves state unchanged.
//    Push and pop together (rd and rs1 both link, rd!=rs1): replace top, tp and cnt
//    unchanged. Entries are written even if rd==rs1, which is treated as push only.
//  - flush: cnt<=0 and tp<=0 next edge. Overrides any same-cycle push/pop. BHT is kept.
//  - BHT update: on upd_valid, counter[upd_pc idx] increments (taken, saturating at 3)
//    or decrements (not taken, saturating at 0) at the next edge.
//    A same-cycle lookup of the same index sees the old value (no bypass).
//    upd_valid is honoured even during flush.
//  - Reset: all counters 2'b01 (weak not-taken), tp=0, cnt=0, RAS data 0.
//    Asserting rst mid-operation clears state immediately.
// TESTING
//  1. Reset, then Bxx at pc=0x100, imm=+0x20, instr[31]=0: pred_taken=0.
//     Apply 2 upd_taken=1 at 0x100 -> pred_taken=1, target=0x120. Apply 3 not-taken -> 0.
//  2. JAL x1 at 0x200 (imm=+0x40) -> target 0x240, RAS top=0x204.
//     JALR x0,0(x1) next -> target 0x204, cnt back to 0, ras_empty=1.
//  3. Five pushes with RAS_DEPTH=4 (pcs 0x10,0x20,0x30,0x40,0x50) then 5 pops
//     -> targets 0x54,0x44,0x34,0x24, then xn path (base r_x1).
//  4. JALR x0,4(x7), rs3v=0x3001, rs1_busy=1 for 2 cycles -> fetch_stall=1 for 2 cycles,
//     then target 0x3004.
//  5. Push at 0x80 with flush=1 in the same cycle -> ras_empty=1 next cycle.
//     MRET with mepc=0x500 -> target 0x500.
//  6. Assert rst asynchronously mid-sequence -> all counters read weak-NT and
//     ras_empty=1 before the next clk edge.

Source files
------------

// File: rtl/fetch_bpu.sv
// fetch_bpu: fetch-stage pre-decode with BHT branch direction and a return address stack.
// Predictions are combinational (0 cycles); fetch_stall holds fetch while a JALR base register is in flight.
module fetch_bpu #(
  parameter int BHT_ENTRIES = 64,
  parameter int RAS_DEPTH   = 4,
  parameter int USE_BHT     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fet_valid,
  input  logic [31:0] fet_pc,
  input  logic [31:0] fet_instr,
  input  logic [31:0] r_x1,
  input  logic [31:0] rs3v,
  input  logic        rs1_busy,
  input  logic [31:0] mepc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        flush,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        fetch_stall,
  output logic        ras_empty
);
  localparam int IDXW = $clog2(BHT_ENTRIES);
  localparam int PW   = $clog2(RAS_DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(RAS_DEPTH);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [1:0]    bht_q [BHT_ENTRIES];
  logic [31:0]   ras_q [RAS_DEPTH];
  logic [PW-1:0] tp_q, tp_d;
  logic [PW:0]   cnt_q, cnt_d;

  logic [6:0]  opc;
  logic [4:0]  rd, rs1;
  logic        is_jal, is_jalr, is_br, is_mret;
  logic        rd_link, rs1_link;
  logic [31:0] jimm, bimm, iimm;
  logic [31:0] xn_base, ras_top, ras_link;
  logic [IDXW-1:0] fet_idx, upd_idx;
  logic [1:0]  fet_ctr, upd_ctr_q, upd_ctr_d;
  logic        br_taken, use_ras, xn_stall, stall;
  logic        ras_fire, do_push, do_swap, do_pop, ras_we;
  logic [PW-1:0] ras_wptr;
  logic        unused_upd;

  assign opc = fet_instr[6:0];
  assign rd  = fet_instr[11:7];
  assign rs1 = fet_instr[19:15];

  assign is_jal  = (opc == OP_JAL);
  assign is_jalr = (opc == OP_JALR);
  assign is_br   = (opc == OP_BRANCH);
  assign is_mret = (opc == OP_SYSTEM) && (fet_instr[31:25] == 7'h18);

  assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);

  assign jimm = {{12{fet_instr[31]}}, fet_instr[19:12], fet_instr[20], fet_instr[30:21], 1'b0};
  assign bimm = {{20{fet_instr[31]}}, fet_instr[7], fet_instr[30:25], fet_instr[11:8], 1'b0};
  assign iimm = {{20{fet_instr[31]}}, fet_instr[31:20]};

  assign fet_idx   = fet_pc[IDXW+1:2];
  assign upd_idx   = upd_pc[IDXW+1:2];
  assign fet_ctr   = bht_q[fet_idx];
  assign upd_ctr_q = bht_q[upd_idx];
  assign br_taken  = (USE_BHT != 0) ? fet_ctr[1] : fet_instr[31];
  assign unused_upd = ^{upd_pc[31:IDXW+2], upd_pc[1:0]};

  assign ras_top  = ras_q[tp_q];
  assign ras_link = fet_pc + 32'd4;
  assign use_ras  = is_jalr && rs1_link && !rd_link && (cnt_q != '0);
  assign xn_stall = is_jalr && !use_ras && (rs1 != 5'd0) && rs1_busy;

  always_comb begin
    if (rs1 == 5'd0)      xn_base = '0;
    else if (rs1 == 5'd1) xn_base = r_x1;
    else                  xn_base = rs3v;
  end

  always_comb begin
    pred_valid  = 1'b0;
    pred_taken  = 1'b0;
    pred_target = '0;
    stall       = 1'b0;
    if (fet_valid && !rst) begin
      if (is_jal) begin
        pred_valid  = 1'b1;
        pred_taken  = 1'b1;
        pred_target = fet_pc + jimm;
      end else if (is_br) begin
        pred_valid  = 1'b1;
        pred_taken  = br_taken;
        pred_target = fet_pc + bimm;
      end else if (is_mret) begin
        pred_valid  = 1'b1;
        pred_taken  = 1'b1;
        pred_target = mepc;
      end else if (is_jalr) begin
        if (use_ras) begin
          pred_valid  = 1'b1;
          pred_taken  = 1'b1;
          pred_target = ras_top;
        end else if (xn_stall) begin
          stall = 1'b1;
        end else begin
          pred_valid  = 1'b1;
          pred_taken  = 1'b1;
          pred_target = (xn_base + iimm) & ~32'd1;
        end
      end
    end
  end

  assign fetch_stall = stall;
  // Outside a valid fetch the RAS reports empty regardless of its contents.
  assign ras_empty   = rst || !fet_valid || (cnt_q == '0);

  assign ras_fire = fet_valid && !stall;
  assign do_push  = (is_jal || is_jalr) && rd_link;
  assign do_swap  = do_push && is_jalr && rs1_link && (rd != rs1);
  assign do_pop   = use_ras;

  always_comb begin
    tp_d     = tp_q;
    cnt_d    = cnt_q;
    ras_we   = 1'b0;
    ras_wptr = tp_q;
    if (flush) begin
      tp_d  = '0;
      cnt_d = '0;
    end else if (ras_fire) begin
      if (do_swap) begin
        ras_we = 1'b1;
      end else if (do_push) begin
        ras_we   = 1'b1;
        ras_wptr = tp_q + 1'b1;
        tp_d     = tp_q + 1'b1;
        if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
      end else if (do_pop) begin
        tp_d  = tp_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
      if (ras_we) ras_q[ras_wptr] <= ras_link;
    end
  end

  always_comb begin
    upd_ctr_d = upd_ctr_q;
    if (upd_taken && (upd_ctr_q != 2'b11))       upd_ctr_d = upd_ctr_q + 2'd1;
    else if (!upd_taken && (upd_ctr_q != 2'b00)) upd_ctr_d = upd_ctr_q - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (upd_valid) begin
      bht_q[upd_idx] <= upd_ctr_d;
    end
  end
endmodule
